// File: rtl/data_mem_ws.sv
// Word-addressed data memory with a fixed number of wait states per access.
// One transaction at a time: IDLE accepts, WAIT counts down, RESP strobes ready_o.
module data_mem_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE_WORDS  = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_req_i,
  input  logic                    write_enable_i,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    ready_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(SIZE_WORDS);
  localparam int TOP   = IDX_W + OFF_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_accept;
  logic                  w_enter_resp;

  logic [31:0]           r_addr;
  logic                  r_we;
  logic [NB-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [31:0]           w_op_addr;
  logic                  w_op_we;
  logic [NB-1:0]         w_op_be;
  logic [DATA_WIDTH-1:0] w_op_wdata;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] r_mem [SIZE_WORDS];

  // With zero wait states RESP is entered on the accept edge itself, before the
  // request registers hold the operands, so the access takes the live inputs then.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_op_addr  = addr_i;
      w_op_we    = write_enable_i;
      w_op_be    = byte_enable_i;
      w_op_wdata = write_data_i;
    end else begin
      w_op_addr  = r_addr;
      w_op_we    = r_we;
      w_op_be    = r_be;
      w_op_wdata = r_wdata;
    end
  end

  assign w_idx    = w_op_addr[TOP-1:OFF_W];
  assign w_oor    = |(w_op_addr >> TOP);
  assign w_unused = ^w_op_addr[OFF_W-1:0];

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_next     = S_WAIT;
            w_cnt_next = WAIT_LOAD;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
  assign ready_o      = (r_state == S_RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      read_data_o <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= addr_i;
        r_we    <= write_enable_i;
        r_be    <= byte_enable_i;
        r_wdata <= write_data_i;
      end
      if (w_enter_resp && !w_op_we) begin
        read_data_o <= w_oor ? '0 : r_mem[w_idx];
      end
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_enter_resp && w_op_we && !w_oor) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (w_op_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_op_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_mem_ws.md
DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data word width in bits (32 or 64).
REQ-002 The block SHALL have parameter SIZE_WORDS, default 4096, memory depth in words (power of two, at least 2).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-004 One clock; reset is asynchronous and active-low: port clk_i  input  1  rising-edge clock.
REQ-005 Port rst_ni  input  1  asynchronous active-low reset.
REQ-006 Port mem_req_i  input  1  request; held high by master until ready_o.
REQ-007 Port write_enable_i  input  1  1 = write, 0 = read.
REQ-008 Port byte_enable_i  input  DATA_WIDTH/8  per-byte write strobe; bit k covers data bits [8k+7:8k].
REQ-009 Port addr_i  input  32  byte address.
REQ-010 Port write_data_i  input  DATA_WIDTH  write data.
REQ-011 Port read_data_o  output  DATA_WIDTH  registered read data.
REQ-012 Port ready_o  output  1  one-cycle transaction-complete strobe.

Function
REQ-013 Word index SHALL be addr_i[log2(SIZE_WORDS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; low offset bits SHALL be ignored.
REQ-014 An address is out of range when any addr_i bit above the index field is 1.
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; reset state IDLE.
REQ-016 IDLE: on a clock edge with mem_req_i=1, SHALL latch addr, we, byte enables and write data; go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-017 WAIT: a counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; at 0 it SHALL go to RESP.
REQ-018 Inputs changing during WAIT or RESP SHALL have no effect; only latched values are used.
REQ-019 On the edge entering RESP, a latched write SHALL update only the bytes whose strobe is 1; other bytes SHALL be unchanged.
REQ-020 On the same edge, a latched read SHALL load read_data_o with the addressed word.
REQ-021 read_data_o SHALL hold its value after writes, after byte_enable=0 transactions and while idle.
REQ-022 ready_o SHALL be 1 exactly during RESP (one cycle) and 0 otherwise.
REQ-023 Latency from the accept edge to ready_o high SHALL be WAIT_CYCLES+1 cycles.
REQ-024 RESP SHALL always go to IDLE; mem_req_i high in RESP SHALL NOT be accepted, so one request gives one transaction.
REQ-025 Back-to-back: a request high in IDLE directly after RESP SHALL be accepted on that IDLE edge.
REQ-026 A write with byte_enable_i all zero SHALL complete normally with ready_o and leave memory unchanged.
REQ-027 An out-of-range write SHALL be dropped; an out-of-range read SHALL return 0; both SHALL still complete with ready_o.
REQ-028 Write then read of the same word SHALL return the written data; there are no hazards, because transactions are serialised.

Reset
REQ-029 rst_ni=0 SHALL immediately force state IDLE, wait counter 0, ready_o 0 and read_data_o 0.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 Reset during WAIT SHALL abort the transaction: no memory write, no ready_o.
REQ-032 The first request after rst_ni rises SHALL be accepted on the first clock edge with mem_req_i=1.

Verification
REQ-033 DW=32, WAIT=2: write 0xDEADBEEF to 0x10, be=4'hF -> ready_o high 3 cycles after the accept edge; read of 0x10 returns 0xDEADBEEF with the same latency.
REQ-034 After REQ-033, write 0x11223344 to 0x10 with be=4'b0101 -> read returns 0xDE22BE44; a write with be=0 leaves it unchanged.
REQ-035 WAIT=0: two back-to-back reads of 0x10 and 0x14 with req held -> ready_o high on alternate cycles; exactly two completions.
REQ-036 SIZE_WORDS=4096, DW=32: read 0x4000 -> ready_o and read_data_o=0; write to 0x4000 -> word 0 unchanged.
REQ-037 Pull rst_ni low mid-WAIT of a write of 0xCAFEF00D to 0x20 -> ready_o 0 and read_data_o 0 at once; a later read of 0x20 returns the prior contents.
REQ-038 DW=64: write 0x0123456789ABCDEF to 0x8, be=8'hF0 -> read of 0x8 returns 0x01234567 in the upper half and the old value in the lower half.
